// File: rtl/rr_arbiter_hold_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
interface rr_arbiter_hold_if #(
    parameter int N_REQ = 4
);
    localparam int W_ID = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [W_ID-1:0]  gnt_id;

    modport master (output req, output done, input gnt, input gnt_valid, input gnt_id);
    modport slave  (input req, input done, output gnt, output gnt_valid, output gnt_id);
endinterface

// File: rtl/rr_arbiter_hold.sv
// Registered round-robin arbiter; a grant is held until done, request drop,
// or an optional hold limit expires while others are waiting.
module rr_arbiter_hold #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_arbiter_hold_if.slave   bus
);
    // state   | meaning
    // IDLE    | no owner, gnt=0, arbitrate on any request
    // GRANTED | gnt frozen on owner until release, then re-arbitrate same cycle
    localparam int W_ID = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int W_HC = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [W_HC-1:0] HC_LIM = W_HC'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t           state;
    logic [N_REQ-1:0] mask;
    logic [W_HC-1:0]  hold_cnt;
    logic [N_REQ-1:0] gnt_q;
    logic             gnt_valid_q;
    logic [W_ID-1:0]  gnt_id_q;

    logic [N_REQ-1:0] rel_mask;
    logic [N_REQ-1:0] arb_mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] win;
    logic [W_ID-1:0]  win_id;
    logic             own_req;
    logic             others;
    logic             hold_hit;
    logic             release_now;

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;

    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rel_mask[i] = (i > int'(gnt_id_q));
        end
        // Owner at the top bit leaves nothing above it: restart from bit 0.
        if (rel_mask == '0) begin
            rel_mask = '1;
        end

        own_req     = |(bus.req & gnt_q);
        others      = |(bus.req & ~gnt_q);
        hold_hit    = (HOLD_MAX != 0) && (hold_cnt == HC_LIM) && others;
        release_now = (state == GRANTED) && (bus.done || !own_req || hold_hit);

        arb_mask = release_now ? rel_mask : mask;
        masked   = bus.req & arb_mask;
        cand     = (|masked) ? masked : bus.req;

        win    = '0;
        win_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win    = '0;
                win[i] = 1'b1;
                win_id = W_ID'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '1;
            hold_cnt    <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q       <= win;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (release_now) begin
                        mask <= rel_mask;
                        if (|bus.req) begin
                            gnt_q       <= win;
                            gnt_id_q    <= win_id;
                            gnt_valid_q <= 1'b1;
                            hold_cnt    <= '0;
                        end else begin
                            gnt_q       <= '0;
                            gnt_id_q    <= '0;
                            gnt_valid_q <= 1'b0;
                            hold_cnt    <= '0;
                            state       <= IDLE;
                        end
                    end else if ((HOLD_MAX != 0) && (hold_cnt != HC_LIM)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
